hc595_rx: RTL and testbench

- Receiving end of the 74HC595 serial display link: samples the ds/shcp/stcp/oe pins driven by the segment-display driver and rebuilds the parallel word the two cascaded '595s would present.
- Used as a synthesizable loop-back checker on the FPGA and as the bench-side decoder for display-driver simulations.
- Checks frame length and flags malformed frames.

---
 rtl/seg595_pkg.sv | 19 +
 rtl/pin_sync_edge.sv | 30 +++
 rtl/hc595_rx.sv | 155 +++++++++++++++
 tb/tb_hc595_rx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seg595_pkg.sv
// Shared definitions for the 74HC595 serial-link receiver: frame geometry
// defaults, bit counter saturation value and control FSM encodings.
package seg595_pkg;

  localparam int DATA_W_DEF = 14;
  localparam int SEL_W_DEF  = 6;
  localparam int CNT_W      = 4;

  // bit counter stops here so runaway shifting cannot wrap back to a legal count
  localparam logic [CNT_W-1:0] CNT_SAT = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2,
    ST_OVER  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/pin_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with a history flop
// behind it so a rising edge can be flagged for one sys_clk cycle.
module pin_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;

  // synchronizer chain plus one history flop, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_r[SYNC_STAGES-1];
  assign rise     = sync_r[SYNC_STAGES-1] & ~hist_r;

endmodule

// File: rtl/hc595_rx.sv
// Receiver for the two-chip 74HC595 display link. Rebuilds the latched
// parallel word from the ds/shcp/stcp/oe pins and reports whether each
// latch followed exactly DATA_W shift clocks.
module hc595_rx
  import seg595_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SEL_W       = SEL_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    ds,
  input  logic                    shcp,
  input  logic                    stcp,
  input  logic                    oe,
  output logic [DATA_W-1:0]       par_out,
  output logic [DATA_W-SEL_W-1:0] seg,
  output logic [SEL_W-1:0]        sel,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic [CNT_W-1:0]        bit_cnt
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

  logic ds_sync_s;
  logic shcp_sync_s;
  logic stcp_sync_s;
  logic oe_sync_s;
  logic shcp_rise_s;
  logic stcp_rise_s;
  logic oe_rise_s;

  ctrl_state_e       state_r;
  ctrl_state_e       state_nx_s;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic [DATA_W-1:0] sr_r;
  logic [DATA_W-1:0] par_r;
  logic              valid_s;
  logic              err_s;
  logic              valid_r;
  logic              err_r;

  // ds goes through the same depth as shcp so the sampled bit lines up with its clock
  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ds (
    .clk(sys_clk), .rst(sys_rst), .din(ds), .sync_out(ds_sync_s), .rise()
  );

  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_shcp (
    .clk(sys_clk), .rst(sys_rst), .din(shcp), .sync_out(shcp_sync_s), .rise(shcp_rise_s)
  );

  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stcp (
    .clk(sys_clk), .rst(sys_rst), .din(stcp), .sync_out(stcp_sync_s), .rise(stcp_rise_s)
  );

  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_oe (
    .clk(sys_clk), .rst(sys_rst), .din(oe), .sync_out(oe_sync_s), .rise(oe_rise_s)
  );

  assign cnt_inc_s = bit_cnt_r + 4'd1;

  // control state register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // next state: a latch always restarts the frame, keeping a coincident shift bit
  always_comb begin
    state_nx_s = state_r;
    if (stcp_rise_s) begin
      if (shcp_rise_s) begin
        state_nx_s = ST_SHIFT;
      end else begin
        state_nx_s = ST_IDLE;
      end
    end else if (shcp_rise_s) begin
      case (state_r)
        ST_IDLE, ST_SHIFT: begin
          if (cnt_inc_s == FULL_CNT) begin
            state_nx_s = ST_FULL;
          end else begin
            state_nx_s = ST_SHIFT;
          end
        end
        ST_FULL, ST_OVER: state_nx_s = ST_OVER;
        default:          state_nx_s = ST_IDLE;
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // frame verdict at latch time, taken from the pre-latch state
  always_comb begin
    valid_s = 1'b0;
    err_s   = 1'b0;
    if (stcp_rise_s) begin
      if (state_r == ST_FULL) begin
        valid_s = 1'b1;
      end else begin
        err_s = 1'b1;
      end
    end else begin
      valid_s = 1'b0;
      err_s   = 1'b0;
    end
  end

  // shift register, bit counter, latched word and registered verdict pulses
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sr_r      <= '0;
      par_r     <= '0;
      bit_cnt_r <= 4'd0;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      valid_r <= valid_s;
      err_r   <= err_s;
      if (shcp_rise_s) begin
        sr_r <= {sr_r[DATA_W-2:0], ds_sync_s};
      end
      if (stcp_rise_s) begin
        par_r     <= sr_r;
        bit_cnt_r <= shcp_rise_s ? 4'd1 : 4'd0;
      end else if (shcp_rise_s && (bit_cnt_r != CNT_SAT)) begin
        bit_cnt_r <= cnt_inc_s;
      end
    end
  end

  // display gating: oe high blanks segments and digit selects, not the word itself
  always_comb begin
    if (oe_sync_s) begin
      seg = '0;
      sel = '0;
    end else begin
      seg = par_r[DATA_W-1:SEL_W];
      sel = par_r[SEL_W-1:0];
    end
  end

  assign par_out     = par_r;
  assign frame_valid = valid_r;
  assign frame_err   = err_r;
  assign bit_cnt     = bit_cnt_r;

endmodule

// File: tb/tb_hc595_rx.sv
// Randomized bench for hc595_rx: drives the 595 pins from tasks and checks
// every latch against a frame-level model (bit list and bit count).
module tb_hc595_rx;

  localparam int DATA_W = 14;
  localparam int SEL_W  = 6;

  logic                    sys_clk = 1'b0;
  logic                    sys_rst;
  logic                    ds, shcp, stcp, oe;
  logic [DATA_W-1:0]       par_out;
  logic [DATA_W-SEL_W-1:0] seg;
  logic [SEL_W-1:0]        sel;
  logic                    frame_valid, frame_err;
  logic [3:0]              bit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // model: every bit shifted since reset, bits since last latch, last latched word
  int unsigned model_word;
  int          model_cnt;
  int unsigned model_par;

  hc595_rx #(.DATA_W(DATA_W), .SEL_W(SEL_W), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe),
    .par_out(par_out), .seg(seg), .sel(sel), .frame_valid(frame_valid),
    .frame_err(frame_err), .bit_cnt(bit_cnt)
  );

  // free-running system clock
  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic shift_bit(input bit b);
    ds = b;
    tick(1);
    shcp = 1'b1;
    tick($urandom_range(1, 3));
    shcp = 1'b0;
    tick($urandom_range(1, 3));
    model_word = ((model_word << 1) | b) & 32'h3FFF;
    model_cnt++;
  endtask

  task automatic check_word(input string tag);
    check_eq({tag, ".par"}, 32'(par_out), model_par);
    check_eq({tag, ".seg"}, 32'(seg), oe ? 32'd0 : (model_par >> SEL_W));
    check_eq({tag, ".sel"}, 32'(sel), oe ? 32'd0 : (model_par & 32'h3F));
  endtask

  // latch the frame; with simul=1 one more shift edge coincides with the latch edge
  task automatic latch(input string tag, input bit simul, input bit b);
    bit exp_v;
    tick(3);
    check_eq({tag, ".cnt_pre"}, 32'(bit_cnt), (model_cnt > 15) ? 32'd15 : 32'(model_cnt));
    if (simul) begin
      ds = b;
      tick(1);
      shcp = 1'b1;
    end
    exp_v     = (model_cnt == DATA_W);
    model_par = model_word;
    stcp      = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      check_eq({tag, ".valid"}, 32'(frame_valid), 32'((k == 3) && exp_v));
      check_eq({tag, ".err"}, 32'(frame_err), 32'((k == 3) && !exp_v));
      if (k == 2) begin
        stcp = 1'b0;
        shcp = 1'b0;
      end
    end
    if (simul) begin
      model_word = ((model_word << 1) | b) & 32'h3FFF;
      model_cnt  = 1;
    end else begin
      model_cnt = 0;
    end
    check_eq({tag, ".cnt_post"}, 32'(bit_cnt), 32'(model_cnt));
    check_word(tag);
  endtask

  task automatic shift_word(input int unsigned w, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
  endtask

  // directed scenarios followed by randomized frames
  initial begin
    int n;
    bit simul;
    sys_rst = 1'b1;
    ds = 1'b0; shcp = 1'b0; stcp = 1'b0; oe = 1'b0;
    model_word = 0; model_cnt = 0; model_par = 0;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      ds = 1'($urandom); shcp = 1'($urandom); stcp = 1'($urandom); oe = 1'($urandom);
      tick(1);
      check_eq("rst.par", 32'(par_out), 32'd0);
      check_eq("rst.segsel", 32'({seg, sel}), 32'd0);
      check_eq("rst.pulse", 32'({frame_valid, frame_err}), 32'd0);
      check_eq("rst.cnt", 32'(bit_cnt), 32'd0);
    end
    ds = 1'b0; shcp = 1'b0; stcp = 1'b0; oe = 1'b0;
    tick(2);
    sys_rst = 1'b0;
    tick(4);
    check_eq("rel.pulse", 32'({frame_valid, frame_err}), 32'd0);
    check_eq("rel.cnt", 32'(bit_cnt), 32'd0);

    shift_word(32'h303E, 14);
    latch("nominal", 1'b0, 1'b0);

    shift_word($urandom, 10);
    latch("short", 1'b0, 1'b0);

    shift_word($urandom, 16);
    latch("overrun", 1'b0, 1'b0);

    shift_word($urandom, 14);
    latch("simul", 1'b1, 1'($urandom));
    latch("simul_tail", 1'b0, 1'b0);

    shift_word(32'h3FFF, 14);
    latch("oe_word", 1'b0, 1'b0);
    oe = 1'b1;
    tick(1);
    check_eq("oe.seg_early", 32'(seg), 32'hFF);
    tick(1);
    check_eq("oe.seg_off", 32'(seg), 32'd0);
    check_eq("oe.sel_off", 32'(sel), 32'd0);
    check_eq("oe.par", 32'(par_out), 32'h3FFF);
    oe = 1'b0;
    tick(2);
    check_eq("oe.seg_on", 32'(seg), 32'hFF);
    check_eq("oe.sel_on", 32'(sel), 32'h3F);

    shift_word($urandom, 5);
    sys_rst = 1'b1;
    tick(2);
    sys_rst = 1'b0;
    model_word = 0; model_cnt = 0; model_par = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_eq("midrst.pulse", 32'({frame_valid, frame_err}), 32'd0);
    end
    check_word("midrst");
    latch("empty", 1'b0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      oe = 1'($urandom_range(0, 3) == 0);
      n  = ($urandom_range(0, 2) == 0) ? 14 : $urandom_range(0, 17);
      simul = ($urandom_range(0, 3) == 0);
      shift_word($urandom, n);
      latch("rand", simul, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
